// File: rtl/candy_fetch_if.sv
// Fetch-controller handshake bundle: SRAM ready, decode stall/redirect/halt in; fetch enable, PC and status out.
// The controller takes the master modport; the environment (fetch stage, decode, bench) takes slave.
interface candy_fetch_if;
  logic        data_ready;
  logic        stall;
  logic        branch_req;
  logic [16:0] branch_target;
  logic        halt;
  logic        if_enable;
  logic [16:0] pc;
  logic        inst_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic        fetch_err;

  modport master (
    input  data_ready, stall, branch_req, branch_target, halt,
    output if_enable, pc, inst_valid, halted, fetch_count, fetch_err
  );

  modport slave (
    output data_ready, stall, branch_req, branch_target, halt,
    input  if_enable, pc, inst_valid, halted, fetch_count, fetch_err
  );
endinterface

// File: rtl/candy_fetch_ctrl.sv
// PC / fetch sequencer: FETCH_ADDR -> FETCH_WAIT -> ISSUE [-> HOLD] -> dispatch; optional SRAM timeout via CANDY_FETCH_TIMEOUT_EN.
// Three cycles minimum per instruction; stall holds the instruction in HOLD; all outputs registered.
module candy_fetch_ctrl #(
  parameter logic [16:0] RESET_PC       = 17'h00000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  candy_fetch_if.master  fif
);

  typedef enum logic [2:0] {
    FETCH_ADDR,
    FETCH_WAIT,
    ISSUE,
    HOLD,
    HALTED,
    ERROR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        dispatch;
  logic [16:0] pc_q;
  logic        if_enable_q;
  logic        inst_valid_q;
  logic        halted_q;
  logic [15:0] fetch_count_q;
  logic        fetch_err_q;

`ifdef CANDY_FETCH_TIMEOUT_EN
  logic [7:0]  wait_cnt;
  logic        wait_limit;
  assign wait_limit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    next_state = state;
    dispatch   = 1'b0;
    case (state)
      FETCH_ADDR: next_state = FETCH_WAIT;
      FETCH_WAIT: begin
        // data_ready beats the timeout when both land in the same cycle
        if (fif.data_ready) begin
          next_state = ISSUE;
        end
`ifdef CANDY_FETCH_TIMEOUT_EN
        else if (wait_limit) begin
          next_state = ERROR;
        end
`endif
      end
      ISSUE, HOLD: begin
        if (fif.stall) begin
          next_state = HOLD;
        end else begin
          dispatch   = 1'b1;
          next_state = fif.halt ? HALTED : FETCH_ADDR;
        end
      end
      HALTED:  next_state = HALTED;
      ERROR:   next_state = ERROR;
      default: next_state = FETCH_ADDR;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH_ADDR;
      pc_q          <= RESET_PC;
      if_enable_q   <= 1'b0;
      inst_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state        <= next_state;
      if_enable_q  <= (next_state == FETCH_ADDR) || (next_state == FETCH_WAIT);
      inst_valid_q <= (next_state == ISSUE) || (next_state == HOLD);
      halted_q     <= (next_state == HALTED);
      if (dispatch) begin
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_q <= fetch_count_q + 16'd1;
        end
        if (!fif.halt) begin
          pc_q <= fif.branch_req ? fif.branch_target : pc_q + 17'd1;
        end
      end
    end
  end

`ifdef CANDY_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      if (state == FETCH_ADDR) begin
        wait_cnt <= 8'd0;
      end else if ((state == FETCH_WAIT) && !fif.data_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (next_state == ERROR) begin
        fetch_err_q <= 1'b1;
      end
    end
  end
`else
  assign fetch_err_q = 1'b0;
`endif

  assign fif.pc          = pc_q;
  assign fif.if_enable   = if_enable_q;
  assign fif.inst_valid  = inst_valid_q;
  assign fif.halted      = halted_q;
  assign fif.fetch_count = fetch_count_q;
  assign fif.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_candy_fetch_ctrl.sv
// Directed bench for candy_fetch_ctrl; a second instance with RESET_PC=17'h1FFFF covers PC wrap.
module tb_candy_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_req = 1'b0;
  logic [16:0] branch_target = 17'h0;
  logic        halt = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  candy_fetch_if f1 ();
  candy_fetch_if f2 ();

  assign f1.data_ready = data_ready;   assign f2.data_ready = data_ready;
  assign f1.stall = stall;             assign f2.stall = stall;
  assign f1.branch_req = branch_req;   assign f2.branch_req = branch_req;
  assign f1.branch_target = branch_target; assign f2.branch_target = branch_target;
  assign f1.halt = halt;               assign f2.halt = halt;

  candy_fetch_ctrl dut (.clk(clk), .rst(rst), .fif(f1));
  candy_fetch_ctrl #(.RESET_PC(17'h1FFFF)) dut_wrap (.clk(clk), .rst(rst), .fif(f2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs in their first FETCH_ADDR cycle with inputs idle.
  task automatic do_reset();
    rst = 1'b1; data_ready = 1'b0; stall = 1'b0; branch_req = 1'b0; halt = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_ready = 1'b1; stall = 1'b1; branch_req = 1'b1; halt = 1'b1;
    step();
    n_checks++;
    if ({f1.if_enable, f1.inst_valid, f1.halted, f1.fetch_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {f1.if_enable, f1.inst_valid, f1.halted, f1.fetch_err});
    end
    n_checks++;
    if (f1.pc !== 17'h00000 || f1.fetch_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_pc_count: got pc=%h cnt=%h expected pc=00000 cnt=0000", f1.pc, f1.fetch_count);
    end
    n_checks++;
    if (f2.pc !== 17'h1FFFF) begin
      n_fail++; $display("FAIL reset_pc_param: got %h expected 1ffff", f2.pc);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (f1.pc !== 17'(i)) begin
        n_fail++; $display("FAIL seq_pc_fetch_addr[%0d]: got %h expected %h", i, f1.pc, 17'(i));
      end
      step();
      n_checks++;
      if ({f1.if_enable, f1.inst_valid} !== 2'b10) begin
        n_fail++; $display("FAIL seq_fetch_wait[%0d]: got en/iv=%b expected 10", i, {f1.if_enable, f1.inst_valid});
      end
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      n_checks++;
      if ({f1.if_enable, f1.inst_valid} !== 2'b01 || f1.pc !== 17'(i)) begin
        n_fail++; $display("FAIL seq_issue[%0d]: got en/iv=%b pc=%h expected 01 pc=%h", i, {f1.if_enable, f1.inst_valid}, f1.pc, 17'(i));
      end
      step();
      n_checks++;
      if ({f1.if_enable, f1.inst_valid} !== 2'b10 || f1.pc !== 17'(i + 1)) begin
        n_fail++; $display("FAIL seq_next_addr[%0d]: got en/iv=%b pc=%h expected 10 pc=%h", i, {f1.if_enable, f1.inst_valid}, f1.pc, 17'(i + 1));
      end
    end
    n_checks++;
    if (f1.fetch_count !== 16'd4) begin
      n_fail++; $display("FAIL seq_fetch_count: got %0d expected 4", f1.fetch_count);
    end
  endtask

  task automatic test_stall_wait();
    do_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({f1.if_enable, f1.inst_valid} !== 2'b10 || f1.pc !== 17'h0) begin
        n_fail++; $display("FAIL wait_hold[%0d]: got en/iv=%b pc=%h expected 10 pc=00000", k, {f1.if_enable, f1.inst_valid}, f1.pc);
      end
      data_ready = (k == 3);
      step();
    end
    data_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stall = (k < 2);
      n_checks++;
      if ({f1.if_enable, f1.inst_valid} !== 2'b01 || f1.pc !== 17'h0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got en/iv=%b pc=%h expected 01 pc=00000", k, {f1.if_enable, f1.inst_valid}, f1.pc);
      end
      step();
    end
    stall = 1'b0;
    n_checks++;
    if (f1.inst_valid !== 1'b0 || f1.pc !== 17'h1 || f1.fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_release: got iv=%b pc=%h cnt=%0d expected 0 00001 1", f1.inst_valid, f1.pc, f1.fetch_count);
    end
  endtask

  task automatic test_branch_wrap();
    do_reset();
    step();
    data_ready = 1'b1; step(); data_ready = 1'b0;
    step();
    n_checks++;
    if (f2.pc !== 17'h00000 || f1.pc !== 17'h00001) begin
      n_fail++; $display("FAIL pc_wrap: got wrap=%h base=%h expected 00000 00001", f2.pc, f1.pc);
    end
    step();
    data_ready = 1'b1; step(); data_ready = 1'b0;
    branch_req = 1'b1; branch_target = 17'h00ABC;
    step();
    branch_req = 1'b0; branch_target = 17'h0;
    n_checks++;
    if (f2.pc !== 17'h00ABC || f1.pc !== 17'h00ABC || f2.fetch_count !== 16'd2) begin
      n_fail++; $display("FAIL branch: got wrap=%h base=%h cnt=%0d expected 00abc 00abc 2", f2.pc, f1.pc, f2.fetch_count);
    end
  endtask

  task automatic test_halt_priority();
    do_reset();
    step();
    data_ready = 1'b1; step(); data_ready = 1'b0;
    halt = 1'b1; branch_req = 1'b1; branch_target = 17'h00123;
    step();
    halt = 1'b0; branch_req = 1'b0;
    n_checks++;
    if ({f1.halted, f1.if_enable, f1.inst_valid} !== 3'b100 || f1.pc !== 17'h0 || f1.fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL halt_entry: got h/en/iv=%b pc=%h cnt=%0d expected 100 00000 1", {f1.halted, f1.if_enable, f1.inst_valid}, f1.pc, f1.fetch_count);
    end
    for (int k = 0; k < 6; k++) begin
      data_ready = k[0]; branch_req = 1'b1;
      step();
      n_checks++;
      if ({f1.halted, f1.if_enable, f1.inst_valid} !== 3'b100 || f1.pc !== 17'h0) begin
        n_fail++; $display("FAIL halt_park[%0d]: got h/en/iv=%b pc=%h expected 100 00000", k, {f1.halted, f1.if_enable, f1.inst_valid}, f1.pc);
      end
    end
    branch_req = 1'b0; data_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (f1.halted !== 1'b0 || f1.fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL halt_reset_exit: got halted=%b cnt=%0d expected 0 0", f1.halted, f1.fetch_count);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    step();
    data_ready = 1'b1; step(); data_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (f1.if_enable !== 1'b1 || f1.pc !== 17'h1) begin
      n_fail++; $display("FAIL midfetch_pre: got en=%b pc=%h expected 1 00001", f1.if_enable, f1.pc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (f1.if_enable !== 1'b0 || f1.pc !== 17'h0 || f1.fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL midfetch_reset: got en=%b pc=%h cnt=%0d expected 0 00000 0", f1.if_enable, f1.pc, f1.fetch_count);
    end
  endtask

`ifdef CANDY_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    step();
    for (int k = 0; k < 15; k++) step();
    n_checks++;
    if (f1.if_enable !== 1'b1 || f1.fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pre: got en=%b err=%b expected 1 0", f1.if_enable, f1.fetch_err);
    end
    step();
    n_checks++;
    if ({f1.fetch_err, f1.if_enable, f1.inst_valid} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_hit: got err/en/iv=%b expected 100", {f1.fetch_err, f1.if_enable, f1.inst_valid});
    end
    data_ready = 1'b1; step(); step(); data_ready = 1'b0;
    n_checks++;
    if ({f1.fetch_err, f1.if_enable, f1.inst_valid} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_sticky: got err/en/iv=%b expected 100", {f1.fetch_err, f1.if_enable, f1.inst_valid});
    end
  endtask

  task automatic test_timeout_ready_wins();
    do_reset();
    step();
    for (int k = 0; k < 15; k++) step();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    n_checks++;
    if ({f1.fetch_err, f1.if_enable, f1.inst_valid} !== 3'b001) begin
      n_fail++; $display("FAIL timeout_ready_wins: got err/en/iv=%b expected 001", {f1.fetch_err, f1.if_enable, f1.inst_valid});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall_wait();
    test_branch_wrap();
    test_halt_priority();
    test_reset_mid_fetch();
`ifdef CANDY_FETCH_TIMEOUT_EN
    test_timeout();
    test_timeout_ready_wins();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
